// File: rtl/bp_fe_bp_tournament_gsh.sv
// Tournament branch predictor built from three counter tables: local, global and selector.
// - The local and selector tables are indexed by the branch index.
// - The global table is indexed by gidx(). Define BP_FE_BP_GSHARE_EN to XOR the history
//   into the index (gshare). Otherwise the index is the zero-extended history alone.
// - After reset, an INIT sweep writes the weakly-not-taken midpoint into every entry.
//   Requests and updates are accepted only once that sweep has finished.
module bp_fe_bp_tournament_gsh #(
  parameter int bht_idx_width_p   = 4,
  parameter int ghist_width_p     = 4,
  parameter int bp_cnt_sat_bits_p = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  output logic                       ready_o,
  input  logic                       r_v_i,
  input  logic [bht_idx_width_p-1:0] idx_r_i,
  output logic                       predict_v_o,
  output logic                       predict_o,
  output logic                       src_o,
  output logic [ghist_width_p-1:0]   ghist_o,
  input  logic                       w_v_i,
  input  logic [bht_idx_width_p-1:0] idx_w_i,
  input  logic [ghist_width_p-1:0]   ghist_w_i,
  input  logic                       taken_i
);

  localparam int entries_lp = 1 << bht_idx_width_p;

  typedef logic [bp_cnt_sat_bits_p-1:0] cnt_t;
  typedef logic [bht_idx_width_p-1:0]   idx_t;
  typedef logic [ghist_width_p-1:0]     gh_t;
  typedef enum logic {e_init, e_ready} state_e;

  // Midpoint value: counters strictly above it predict taken (or select global).
  localparam cnt_t half_lp = {1'b0, {(bp_cnt_sat_bits_p-1){1'b1}}};
  localparam cnt_t max_lp  = {bp_cnt_sat_bits_p{1'b1}};
  localparam idx_t last_lp = idx_t'(entries_lp - 1);

  function automatic idx_t gidx(idx_t i, gh_t h);
    idx_t ext;
    ext = '0;
    ext[ghist_width_p-1:0] = h;
`ifdef BP_FE_BP_GSHARE_EN
    return i ^ ext;
`else
    return ext;
`endif
  endfunction

  function automatic cnt_t sat_step(cnt_t c, logic up);
    if (up) return (c == max_lp) ? c : c + cnt_t'(1);
    else    return (c == '0)     ? c : c - cnt_t'(1);
  endfunction

  // NOTE: the tables deliberately have no reset. The INIT sweep is what gives them
  // defined contents, which keeps them mappable onto plain RAM.
  cnt_t local_mem  [entries_lp];
  cnt_t global_mem [entries_lp];
  cnt_t sel_mem    [entries_lp];

  state_e state_q, state_d;
  idx_t   sweep_q, sweep_d;
  gh_t    gh_q, gh_d;
  logic   predict_v_q, predict_v_d;
  logic   predict_q, predict_d;
  logic   src_q, src_d;
  gh_t    ghist_q, ghist_d;

  logic   accept_r, accept_w;
  idx_t   r_gidx, w_gidx;
  cnt_t   r_loc, r_glb, r_sel;
  cnt_t   w_loc, w_glb, w_sel;
  logic   loc_ok, glb_ok;

  logic   tbl_we;
  idx_t   loc_addr, glb_addr;
  cnt_t   loc_wdata, glb_wdata, sel_wdata;

  assign ready_o     = (state_q == e_ready);
  assign predict_v_o = predict_v_q;
  assign predict_o   = predict_q;
  assign src_o       = src_q;
  assign ghist_o     = ghist_q;

  // Table reads use the current (pre-edge) contents, so a same-cycle update is never seen.
  always_comb begin
    accept_r = r_v_i & ready_o & ~reset_i;
    accept_w = w_v_i & ready_o & ~reset_i;
    r_gidx   = gidx(idx_r_i, gh_q);
    w_gidx   = gidx(idx_w_i, ghist_w_i);
    r_loc    = local_mem[idx_r_i];
    r_glb    = global_mem[r_gidx];
    r_sel    = sel_mem[idx_r_i];
    w_loc    = local_mem[idx_w_i];
    w_glb    = global_mem[w_gidx];
    w_sel    = sel_mem[idx_w_i];
    loc_ok   = ((w_loc > half_lp) == taken_i);
    glb_ok   = ((w_glb > half_lp) == taken_i);
  end

  // Table write port: the INIT sweep has priority; an accepted update is used otherwise.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    tbl_we    = 1'b0;
    loc_addr  = idx_w_i;
    glb_addr  = w_gidx;
    loc_wdata = sat_step(w_loc, taken_i);
    glb_wdata = sat_step(w_glb, taken_i);
    sel_wdata = w_sel;
    if (state_q == e_init) begin
      tbl_we    = ~reset_i;
      loc_addr  = sweep_q;
      glb_addr  = sweep_q;
      loc_wdata = half_lp;
      glb_wdata = half_lp;
      sel_wdata = half_lp;
    end else if (accept_w) begin
      tbl_we = 1'b1;
      if (!loc_ok && glb_ok)      sel_wdata = sat_step(w_sel, 1'b1);
      else if (loc_ok && !glb_ok) sel_wdata = sat_step(w_sel, 1'b0);
    end
  end

  // Write the three tables from the single shared port.
  always_ff @(posedge clk_i) begin
    if (tbl_we) begin
      // NOTE: sequential state uses non-blocking assignments, so every read in this
      // cycle sees the pre-edge values.
      local_mem[loc_addr]  <= loc_wdata;
      global_mem[glb_addr] <= glb_wdata;
      sel_mem[loc_addr]    <= sel_wdata;
    end
  end

  // Next-state logic: INIT sweep progress, history shift and prediction outputs.
  always_comb begin
    state_d     = state_q;
    sweep_d     = sweep_q;
    gh_d        = gh_q;
    predict_v_d = 1'b0;
    predict_d   = predict_q;
    src_d       = src_q;
    ghist_d     = ghist_q;
    case (state_q)
      e_init: begin
        sweep_d = sweep_q + idx_t'(1);
        if (sweep_q == last_lp) state_d = e_ready;
      end
      default: begin
        if (accept_w) gh_d = gh_t'({gh_q, taken_i});
        if (accept_r) begin
          predict_v_d = 1'b1;
          src_d       = (r_sel > half_lp);
          predict_d   = (r_sel > half_lp) ? (r_glb > half_lp) : (r_loc > half_lp);
          ghist_d     = gh_q;
        end
      end
    endcase
  end

  // Control and output registers. A synchronous reset restarts the INIT sweep.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= e_init;
      sweep_q     <= '0;
      gh_q        <= '0;
      predict_v_q <= 1'b0;
      predict_q   <= 1'b0;
      src_q       <= 1'b0;
      ghist_q     <= '0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      gh_q        <= gh_d;
      predict_v_q <= predict_v_d;
      predict_q   <= predict_d;
      src_q       <= src_d;
      ghist_q     <= ghist_d;
    end
  end

endmodule

// File: tb/tb_bp_fe_bp_tournament_gsh.sv
// Bench for bp_fe_bp_tournament_gsh (idx=4, ghist=4, 2-bit counters).
// The reference model keeps the tables as integer arrays and applies the predictor
// rules arithmetically. The same BP_FE_BP_GSHARE_EN macro selects its index function.
module tb_bp_fe_bp_tournament_gsh;

  localparam int N    = 16;
  localparam int HALF = 1;
  localparam int MAXC = 3;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic       ready_o;
  logic       r_v_i = 1'b0;
  logic [3:0] idx_r_i = '0;
  logic       predict_v_o, predict_o, src_o;
  logic [3:0] ghist_o;
  logic       w_v_i = 1'b0;
  logic [3:0] idx_w_i = '0;
  logic [3:0] ghist_w_i = '0;
  logic       taken_i = 1'b0;

  always #5 clk = ~clk;

  bp_fe_bp_tournament_gsh #(
    .bht_idx_width_p(4), .ghist_width_p(4), .bp_cnt_sat_bits_p(2)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .ready_o(ready_o),
    .r_v_i(r_v_i), .idx_r_i(idx_r_i),
    .predict_v_o(predict_v_o), .predict_o(predict_o), .src_o(src_o), .ghist_o(ghist_o),
    .w_v_i(w_v_i), .idx_w_i(idx_w_i), .ghist_w_i(ghist_w_i), .taken_i(taken_i)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int   m_local [N];
  int   m_glob  [N];
  int   m_sel   [N];
  int   m_gh    = 0;
  bit   m_init  = 1'b1;
  int   m_sweep = 0;
  logic exp_v = 1'b0, exp_p = 1'b0, exp_src = 1'b0, exp_ready = 1'b0;
  logic [3:0] exp_gh = '0;

  function automatic int gidx(int i, int h);
`ifdef BP_FE_BP_GSHARE_EN
    return (i ^ h) & (N - 1);
`else
    return h & (N - 1);
`endif
  endfunction

  function automatic int bump(int c, bit up);
    if (up) return (c < MAXC) ? c + 1 : MAXC;
    return (c > 0) ? c - 1 : 0;
  endfunction

  // Drive one cycle of inputs, advance the model, then wait until just past the edge.
  task automatic step(input bit rst, input bit rv, input int ridx,
                      input bit wv, input int widx, input int wgh, input bit tk);
    int gi, l, g;
    bit lok, gok;
    reset_i = rst; r_v_i = rv; idx_r_i = 4'(ridx);
    w_v_i = wv; idx_w_i = 4'(widx); ghist_w_i = 4'(wgh); taken_i = tk;
    if (rst) begin
      m_init = 1'b1; m_sweep = 0; m_gh = 0;
      exp_v = 0; exp_p = 0; exp_src = 0; exp_gh = '0;
    end else begin
      if (rv && !m_init) begin
        exp_v   = 1'b1;
        exp_src = (m_sel[ridx] > HALF);
        exp_p   = exp_src ? (m_glob[gidx(ridx, m_gh)] > HALF) : (m_local[ridx] > HALF);
        exp_gh  = 4'(m_gh);
      end else begin
        exp_v = 1'b0;
      end
      if (m_init) begin
        m_local[m_sweep] = HALF; m_glob[m_sweep] = HALF; m_sel[m_sweep] = HALF;
        if (m_sweep == N - 1) m_init = 1'b0;
        m_sweep++;
      end else if (wv) begin
        gi  = gidx(widx, wgh);
        l   = m_local[widx];
        g   = m_glob[gi];
        lok = ((l > HALF) == tk);
        gok = ((g > HALF) == tk);
        m_local[widx] = bump(l, tk);
        m_glob[gi]    = bump(g, tk);
        if (!lok && gok)      m_sel[widx] = bump(m_sel[widx], 1'b1);
        else if (lok && !gok) m_sel[widx] = bump(m_sel[widx], 1'b0);
        m_gh = ((m_gh << 1) | int'(tk)) & (N - 1);
      end
    end
    exp_ready = !m_init;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    int zeros;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 5, 1, 3, 0, 1);
    total++;
    if ({predict_v_o, predict_o, src_o, ghist_o, ready_o} !== 8'b0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b",
               {predict_v_o, predict_o, src_o, ghist_o, ready_o}, 8'b0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    zeros = 0;
    for (int k = 0; k < 40 && ready_o !== 1'b1; k++) begin
      total++;
      if (ready_o !== exp_ready) begin
        bad++; $display("FAIL init_ready k=%0d got=%b want=%b", k, ready_o, exp_ready);
      end
      zeros++;
      idle();
    end
    // The first sample after the reset edge is 0 as well, so 16 samples are expected.
    total++;
    if (zeros + 1 != 16) begin
      bad++; $display("FAIL init_length got=%0d want=16", zeros + 1);
    end
    step(0, 1, 5, 0, 0, 0, 0);
    total++;
    if ({predict_v_o, predict_o, src_o, ghist_o} !== {exp_v, exp_p, exp_src, exp_gh} ||
        {predict_v_o, predict_o, src_o, ghist_o} !== 7'b1000000) begin
      bad++;
      $display("FAIL first_predict got=%b want=%b",
               {predict_v_o, predict_o, src_o, ghist_o}, 7'b1000000);
    end
  endtask

  task automatic test_saturation();
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 0, 1, 3, 0, k < 4);
      total++;
      if (int'(dut.local_mem[3]) !== m_local[3]) begin
        bad++;
        $display("FAIL sat_local3 k=%0d got=%0d want=%0d", k, dut.local_mem[3], m_local[3]);
      end
    end
    total++;
    if (int'(dut.local_mem[3]) !== 0) begin
      bad++; $display("FAIL sat_floor got=%0d want=0", dut.local_mem[3]);
    end
  endtask

  task automatic test_reinit();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 7; k++) idle();
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) begin
      step(0, 0, 0, 1, 0, 9, 1);
      total++;
      if (ready_o !== exp_ready || ready_o !== (k == 15)) begin
        bad++; $display("FAIL reinit_ready k=%0d got=%b want=%b", k, ready_o, k == 15);
      end
    end
    total++;
    if (int'(dut.local_mem[0]) !== m_local[0] || int'(dut.global_mem[9]) !== m_glob[9]) begin
      bad++;
      $display("FAIL init_drop local0=%0d glob9=%0d want=%0d/%0d",
               dut.local_mem[0], dut.global_mem[9], m_local[0], m_glob[9]);
    end
    step(0, 1, 0, 0, 0, 0, 0);
    total++;
    if (ghist_o !== exp_gh || ghist_o !== 4'b0000) begin
      bad++; $display("FAIL init_gh got=%b want=0000", ghist_o);
    end
  endtask

  task automatic test_ghist();
    step(0, 0, 0, 1, 7, 0, 1);
    step(0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 1, 7, 0, 1);
    step(0, 1, 7, 1, 7, 0, 1);
    total++;
    if (ghist_o !== exp_gh || ghist_o !== 4'b0101) begin
      bad++; $display("FAIL gh_same_cycle got=%b want=0101", ghist_o);
    end
    step(0, 1, 7, 0, 0, 0, 0);
    total++;
    if (ghist_o !== exp_gh || ghist_o !== 4'b1011) begin
      bad++; $display("FAIL gh_after got=%b want=1011", ghist_o);
    end
  endtask

  task automatic test_selector();
    logic [3:0] snap;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) idle();
    for (int k = 0; k < 24; k++) begin
      step(0, 1, 2, 0, 0, 0, 0);
      total++;
      if ({predict_v_o, predict_o, src_o, ghist_o} !== {exp_v, exp_p, exp_src, exp_gh}) begin
        bad++;
        $display("FAIL sel_train k=%0d got=%b want=%b", k,
                 {predict_v_o, predict_o, src_o, ghist_o}, {exp_v, exp_p, exp_src, exp_gh});
      end
      snap = ghist_o;
      step(0, 0, 0, 1, 2, int'(snap), (k % 2) == 0);
    end
    step(0, 1, 2, 0, 0, 0, 0);
    total++;
    if (src_o !== 1'b1 || predict_o !== 1'b1 || dut.sel_mem[2] <= 2'd1) begin
      bad++;
      $display("FAIL sel_learned src=%b pred=%b sel2=%0d want src=1 pred=1 sel2>1",
               src_o, predict_o, dut.sel_mem[2]);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if (int'(dut.global_mem[i]) !== m_glob[i]) begin
        bad++;
        $display("FAIL sel_glob[%0d] got=%0d want=%0d", i, dut.global_mem[i], m_glob[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] snaps[$];
    int wgh;
    step(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 600; k++) begin
      if (snaps.size() > 0 && $urandom_range(3) != 0) wgh = int'(snaps.pop_front());
      else wgh = int'($urandom_range(N - 1));
      step($urandom_range(199) == 0, $urandom_range(1) == 1, int'($urandom_range(N - 1)),
           $urandom_range(2) != 0, int'($urandom_range(N - 1)), wgh, $urandom_range(1) == 1);
      if (exp_v) snaps.push_back(exp_gh);
      total++;
      if ({ready_o, predict_v_o, predict_o, src_o, ghist_o} !==
          {exp_ready, exp_v, exp_p, exp_src, exp_gh}) begin
        bad++;
        $display("FAIL rand k=%0d got=%b want=%b", k,
                 {ready_o, predict_v_o, predict_o, src_o, ghist_o},
                 {exp_ready, exp_v, exp_p, exp_src, exp_gh});
      end
    end
    for (int k = 0; k < 20; k++) idle();
    for (int i = 0; i < N; i++) begin
      total++;
      if (int'(dut.local_mem[i]) !== m_local[i] || int'(dut.global_mem[i]) !== m_glob[i] ||
          int'(dut.sel_mem[i]) !== m_sel[i]) begin
        bad++;
        $display("FAIL rand_tables[%0d] got=%0d/%0d/%0d want=%0d/%0d/%0d", i,
                 dut.local_mem[i], dut.global_mem[i], dut.sel_mem[i],
                 m_local[i], m_glob[i], m_sel[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      m_local[i] = HALF; m_glob[i] = HALF; m_sel[i] = HALF;
    end
    test_reset();
    test_saturation();
    test_reinit();
    test_ghist();
    test_selector();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
